// File: rtl/rope_pkg.sv
// rtl/rope_pkg.sv - shared types, speed table and init helpers for the rope scheduler
package rope_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    LOAD
  } state_t;

  localparam int COORD_W = 11;
  localparam int SPEED_W = 8;

  // Signed pixel X as reported by a rope mover.
  typedef logic signed [COORD_W-1:0] coord_t;
  // Signed speed, FIXED_POINT_MULTIPLIER counts per pixel per frame.
  typedef logic signed [SPEED_W-1:0] speed_t;

  localparam int FIXED_POINT_MULTIPLIER = 64;

  // Per-level speed magnitude: 0.5, 0.75, 1.0 and 1.5 pixels per frame.
  localparam logic [SPEED_W-1:0] BASE_SPEED [4] = '{
    SPEED_W'(FIXED_POINT_MULTIPLIER / 2),
    SPEED_W'(FIXED_POINT_MULTIPLIER * 3 / 4),
    SPEED_W'(FIXED_POINT_MULTIPLIER),
    SPEED_W'(FIXED_POINT_MULTIPLIER * 3 / 2)
  };

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  // Even ropes start moving right, odd ropes start moving left.
  function automatic logic init_dir(input int idx);
    return idx[0] ? DIR_LEFT : DIR_RIGHT;
  endfunction

  // Starting speed carries the sign of the starting direction.
  function automatic speed_t init_speed(input logic [1:0] lvl, input int idx);
    speed_t s;
    s = speed_t'(BASE_SPEED[lvl]);
    return idx[0] ? -s : s;
  endfunction

endpackage

// File: rtl/rope_bound_check.sv
// rtl/rope_bound_check.sv - decides whether one rope has reached the bound it is heading to
module rope_bound_check
  import rope_pkg::*;
(
  input  logic   enable,
  input  logic   dir,
  input  coord_t x,
  input  coord_t left_bound,
  input  coord_t right_bound,
  output logic   hit
);

  // Signed compare so a rope that has drifted to negative X still counts as past the left edge.
  always_comb begin
    hit = 1'b0;
    if (enable) begin
      if (dir == DIR_RIGHT) begin
        hit = (x >= right_bound);
      end else begin
        hit = (x <= left_bound);
      end
    end
  end

endmodule

// File: rtl/rope_scheduler.sv
// rtl/rope_scheduler.sv - staggers rope enables, assigns speeds and reverses ropes at playfield bounds
module rope_scheduler
  import rope_pkg::*;
#(
  parameter int NUM_ROPES    = 4,
  parameter int LEFT_BOUND   = 40,
  parameter int RIGHT_BOUND  = 560,
  parameter int SPAWN_FRAMES = 90
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         startOfFrame,
  input  logic                         pause,
  input  logic [1:0]                   level,
  input  logic [NUM_ROPES*COORD_W-1:0] rope_x,
  output logic [NUM_ROPES-1:0]         rope_en,
  output logic [NUM_ROPES-1:0]         dir_toggle,
  output logic [NUM_ROPES*SPEED_W-1:0] rope_speed,
  output logic                         rope_load,
  output logic                         busy
);

  localparam int IDX_W  = (NUM_ROPES > 1) ? $clog2(NUM_ROPES) : 1;
  localparam int ACT_W  = $clog2(NUM_ROPES + 1);
  localparam int CNT_W  = (SPAWN_FRAMES > 2) ? $clog2(SPAWN_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_FRAMES - 1);

  state_t                 state;
  logic [IDX_W-1:0]       scan_idx;
  logic [ACT_W-1:0]       active_cnt;
  logic [CNT_W-1:0]       frame_cnt;
  logic [1:0]             level_q;
  logic [NUM_ROPES-1:0]   dir_q;

  coord_t                 cur_x;
  logic                   cur_en;
  logic                   cur_dir;
  logic                   cur_hit;

  // Only one rope is examined per cycle, so a single bound checker is shared.
  assign cur_x   = rope_x[int'(scan_idx)*COORD_W +: COORD_W];
  assign cur_en  = rope_en[scan_idx];
  assign cur_dir = dir_q[scan_idx];

  rope_bound_check u_bound_check (
    .enable      (cur_en),
    .dir         (cur_dir),
    .x           (cur_x),
    .left_bound  (coord_t'(LEFT_BOUND)),
    .right_bound (coord_t'(RIGHT_BOUND)),
    .hit         (cur_hit)
  );

  // Scheduler FSM: frame acceptance and spawning in IDLE, one rope per cycle in SCAN, re-init in LOAD.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      scan_idx   <= '0;
      dir_toggle <= '0;
      rope_load  <= 1'b0;
      busy       <= 1'b0;
      rope_en    <= NUM_ROPES'(1);
      active_cnt <= ACT_W'(1);
      frame_cnt  <= '0;
      level_q    <= level;
      for (int i = 0; i < NUM_ROPES; i++) begin
        dir_q[i]                       <= init_dir(i);
        rope_speed[i*SPEED_W +: SPEED_W] <= init_speed(level, i);
      end
    end else begin
      dir_toggle <= '0;
      rope_load  <= 1'b0;
      case (state)
        IDLE: begin
          // A level change must win over a frame arriving in the same cycle.
          if (level != level_q) begin
            state     <= LOAD;
            rope_load <= 1'b1;
            busy      <= 1'b1;
          end else if (startOfFrame && !pause) begin
            state    <= SCAN;
            scan_idx <= '0;
            busy     <= 1'b1;
            if (frame_cnt == CNT_LAST) begin
              // Counter parks at its last value once every rope is out.
              if (active_cnt < ACT_W'(NUM_ROPES)) begin
                rope_en[active_cnt] <= 1'b1;
                active_cnt          <= active_cnt + 1'b1;
                frame_cnt           <= '0;
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end

        SCAN: begin
          // Flipping the tracked direction stops a rope sitting on a bound from toggling every frame.
          if (cur_hit) begin
            dir_toggle[scan_idx] <= 1'b1;
            dir_q[scan_idx]      <= ~dir_q[scan_idx];
          end
          if (scan_idx == IDX_W'(NUM_ROPES - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end

        LOAD: begin
          level_q    <= level;
          rope_en    <= NUM_ROPES'(1);
          active_cnt <= ACT_W'(1);
          frame_cnt  <= '0;
          for (int i = 0; i < NUM_ROPES; i++) begin
            dir_q[i]                         <= init_dir(i);
            rope_speed[i*SPEED_W +: SPEED_W] <= init_speed(level, i);
          end
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rope_scheduler.sv
// tb/tb_rope_scheduler.sv - randomized and directed self-checking bench for rope_scheduler
module tb_rope_scheduler;

  localparam int N  = 4;
  localparam int LB = 40;
  localparam int RB = 560;
  localparam int SF = 90;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             sof = 1'b0;
  logic             pause = 1'b0;
  logic [1:0]       level = 2'd0;
  logic [N*11-1:0]  rope_x;
  logic [N-1:0]     rope_en;
  logic [N-1:0]     dir_toggle;
  logic [N*8-1:0]   rope_speed;
  logic             rope_load;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int tog_events = 0;

  int bases [4] = '{32, 48, 64, 96};

  // Reference model state
  int   m_active;
  int   m_frames;
  int   m_level;
  bit   m_right [N];
  int   m_scan = -1;
  bit   m_loading = 1'b0;
  bit   m_valid = 1'b0;
  logic [N-1:0] e_toggle;
  bit   e_load;

  rope_scheduler #(
    .NUM_ROPES    (N),
    .LEFT_BOUND   (LB),
    .RIGHT_BOUND  (RB),
    .SPAWN_FRAMES (SF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .startOfFrame (sof),
    .pause        (pause),
    .level        (level),
    .rope_x       (rope_x),
    .rope_en      (rope_en),
    .dir_toggle   (dir_toggle),
    .rope_speed   (rope_speed),
    .rope_load    (rope_load),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int x_of(input int i);
    logic signed [10:0] v;
    v = rope_x[i*11 +: 11];
    return int'(v);
  endfunction

  task automatic model_init();
    m_active = 1;
    m_frames = 0;
    m_level  = int'(level);
    for (int i = 0; i < N; i++) m_right[i] = (i % 2 == 0);
  endtask

  // Model advance on each edge, then compare all outputs just after the edge.
  always begin
    logic [N-1:0]   en_exp;
    logic [N*8-1:0] sp_exp;
    int             s;
    int             i;
    bit             hit;
    @(posedge clk);
    e_toggle = '0;
    e_load   = 1'b0;
    if (reset) begin
      model_init();
      m_scan    = -1;
      m_loading = 1'b0;
      m_valid   = 1'b1;
    end else if (m_valid) begin
      if (m_loading) begin
        model_init();
        m_loading = 1'b0;
      end else if (m_scan >= 0) begin
        i = m_scan;
        hit = m_right[i] ? (x_of(i) >= RB) : (x_of(i) <= LB);
        if (i < m_active && hit) begin
          e_toggle[i] = 1'b1;
          m_right[i]  = !m_right[i];
        end
        m_scan = (m_scan == N - 1) ? -1 : m_scan + 1;
      end else if (int'(level) != m_level) begin
        m_loading = 1'b1;
        e_load    = 1'b1;
      end else if (sof && !pause) begin
        if (m_frames == SF - 1 && m_active < N) begin
          m_active++;
          m_frames = 0;
        end else if (m_frames < SF - 1) begin
          m_frames++;
        end
        m_scan = 0;
      end
    end
    #1;
    if (m_valid) begin
      en_exp = N'((1 << m_active) - 1);
      for (int k = 0; k < N; k++) begin
        s = bases[m_level];
        if (k % 2 == 1) s = -s;
        sp_exp[k*8 +: 8] = 8'(s);
      end
      check("model_rope_en", rope_en, en_exp);
      check("model_dir_toggle", dir_toggle, e_toggle);
      check("model_rope_speed", rope_speed, sp_exp);
      check("model_rope_load", rope_load, e_load);
      check("model_busy", busy, (m_scan >= 0) || m_loading);
      if (dir_toggle != '0) tog_events++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_x(input int i, input int v);
    rope_x[i*11 +: 11] = 11'(v);
  endtask

  task automatic frame();
    @(negedge clk);
    sof = 1'b1;
    @(negedge clk);
    sof = 1'b0;
    tick(N + 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t0;
    int v;
    rope_x = '0;
    for (int i = 0; i < N; i++) set_x(i, 300);
    level = 2'd0;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;

    // Reset state
    check("rst_rope_en", rope_en, 4'b0001);
    check("rst_rope_speed", rope_speed, 32'hE020E020);
    check("rst_busy", busy, 1'b0);
    check("rst_dir_toggle", dir_toggle, 4'b0000);
    check("rst_rope_load", rope_load, 1'b0);

    // Right bound toggle, exactly two cycles after the frame pulse
    set_x(0, 560);
    @(negedge clk);
    sof = 1'b1;
    @(negedge clk);
    sof = 1'b0;
    check("toggle_cycle1", dir_toggle, 4'b0000);
    @(negedge clk);
    check("toggle_cycle2", dir_toggle, 4'b0001);
    @(negedge clk);
    check("toggle_cycle3", dir_toggle, 4'b0000);
    tick(N);
    t0 = tog_events;
    frame();
    check("no_retoggle", tog_events - t0, 0);
    set_x(0, 40);
    t0 = tog_events;
    frame();
    check("left_toggle", tog_events - t0, 1);

    // Staggered spawn
    set_x(0, 300);
    do_reset();
    repeat (SF - 1) frame();
    check("spawn_89", rope_en, 4'b0001);
    frame();
    check("spawn_90", rope_en, 4'b0011);
    repeat (2 * SF) frame();
    check("spawn_270", rope_en, 4'b1111);
    repeat (20) frame();
    check("spawn_sat", rope_en, 4'b1111);

    // Level change beats a simultaneous frame
    @(negedge clk);
    level = 2'd2;
    sof = 1'b1;
    @(negedge clk);
    sof = 1'b0;
    check("load_pulse", rope_load, 1'b1);
    check("load_busy", busy, 1'b1);
    @(negedge clk);
    check("load_done", rope_load, 1'b0);
    check("load_speed", rope_speed, 32'hC040C040);
    check("load_en", rope_en, 4'b0001);
    check("load_noscan", busy, 1'b0);

    // Pause freezes scheduling
    set_x(0, 600);
    pause = 1'b1;
    t0 = tog_events;
    repeat (200) frame();
    check("pause_notoggle", tog_events - t0, 0);
    check("pause_en", rope_en, 4'b0001);
    pause = 1'b0;
    frame();
    check("unpause_toggle", tog_events - t0, 1);

    // Reset in the middle of a scan suppresses the pending toggle
    level = 2'd0;
    do_reset();
    @(negedge clk);
    sof = 1'b1;
    @(negedge clk);
    sof = 1'b0;
    reset = 1'b1;
    t0 = tog_events;
    @(negedge clk);
    reset = 1'b0;
    check("midscan_toggle", dir_toggle, 4'b0000);
    check("midscan_en", rope_en, 4'b0001);
    check("midscan_speed", rope_speed, 32'hE020E020);
    check("midscan_busy", busy, 1'b0);
    tick(N + 2);
    check("midscan_quiet", tog_events - t0, 0);

    // Randomized traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      sof   = ($urandom_range(0, 3) == 0);
      pause = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 399) == 0) level = 2'($urandom_range(0, 3));
      reset = ($urandom_range(0, 999) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          v = int'($urandom_range(0, 800)) - 100;
          set_x(i, v);
        end
      end
    end
    @(negedge clk);
    sof = 1'b0;
    reset = 1'b0;
    pause = 1'b0;
    tick(N + 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rope_scheduler.md
Name: rope_scheduler

Overview:
- Central controller for up to NUM_ROPES horizontally moving rope objects.
- Enables ropes in a staggered sequence, assigns each rope its per-level speed, and watches reported rope X positions once per frame.
- Issues single-cycle direction-toggle pulses at the playfield bounds and re-initialises all ropes on level change.
- Sits between the game-level logic and the per-rope movers, in the VGA object layer.

Parameters:
- NUM_ROPES, 4, number of managed ropes (1..8).
- LEFT_BOUND, 40, pixel X at or below which a left-moving rope is reversed.
- RIGHT_BOUND, 560, pixel X at or above which a right-moving rope is reversed.
- SPAWN_FRAMES, 90, frames between successive rope enables.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse per frame.
- pause  in  1  freeze scheduling while high.
- level  in  2  current game level.
- rope_x  in  NUM_ROPES*11  packed signed pixel X of each rope; rope i is bits [11i+10:11i].
- rope_en  out  NUM_ROPES  rope i drawn and moving.
- dir_toggle  out  NUM_ROPES  one-cycle reverse pulse per rope.
- rope_speed  out  NUM_ROPES*8  packed signed speed, fixed point, 64 = 1 pixel/frame.
- rope_load  out  1  one-cycle pulse; movers reload their initial position and speed.
- busy  out  1  high in SCAN/LOAD.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - rope_en = 0...01; dir_toggle = 0; rope_load = 0; busy = 0.
  - Internal direction bits: even index = right, odd index = left.
  - rope_speed(i) = +BASE_SPEED[level] for even i, -BASE_SPEED[level] for odd i.
  - Frame counter = 0; active count = 1; registered level = level; state IDLE.
- FSM states: IDLE, SCAN, LOAD.
- IDLE:
  - If level != registered level, go to LOAD. This takes priority over startOfFrame in the same cycle.
  - Otherwise, on startOfFrame with pause=0: go to SCAN with index 0, and advance the spawn counter.
- SCAN, one rope per cycle at index i:
  - If rope i is enabled and either (dir=right and x >= RIGHT_BOUND) or (dir=left and x <= LEFT_BOUND), then:
    - dir_toggle[i] pulses high in the following cycle;
    - the internal direction bit flips, so the same rope is never toggled twice per crossing;
    - rope_speed(i) keeps its reset-time sign; the mover owns the sign.
  - After i = NUM_ROPES-1, go to IDLE. A scan takes exactly NUM_ROPES cycles; the last toggle pulse lands one cycle after SCAN exits.
  - Comparisons are signed 11-bit. A negative X always counts as at or below LEFT_BOUND.
  - startOfFrame during SCAN is dropped: no new scan, no counter advance.
- LOAD (one cycle):
  - rope_load = 1; registered level := level.
  - rope_speed and direction bits are re-initialised as at reset using the new level.
  - rope_en = 0...01; active count = 1; frame counter = 0; then go to IDLE.
- Spawn:
  - The frame counter increments on each accepted frame.
  - When it reaches SPAWN_FRAMES-1 and active count < NUM_ROPES: rope_en bit [active count] sets, active count increments, counter clears.
  - At NUM_ROPES active, the counter saturates at SPAWN_FRAMES-1.
- pause=1: startOfFrame is ignored completely. Level change is still honoured.
- Reset asserted mid-SCAN or mid-LOAD: all state returns to reset values on the next edge, and no pending toggle pulse is emitted.
- Only rope_load and dir_toggle are pulses; every other output is registered level.

Decomposition:
- Package rope_pkg holds:
  - typedef state_t {IDLE, SCAN, LOAD};
  - BASE_SPEED table indexed by level: {32, 48, 64, 96};
  - constant FIXED_POINT_MULTIPLIER = 64;
  - typedef for the signed 11-bit coordinate.
- One sub-module is natural: rope_bound_check. It is combinational: x, dir, bounds, enable -> hit.

Test Plan:
- Reset with level=0: rope_en=0001, rope_speed = {-32, +32, -32, +32} (rope3..rope0), busy=0, no pulses.
- rope_x[0]=560, direction right, one startOfFrame: dir_toggle[0] high exactly in cycle 2 after the pulse. A second frame with x still 560 gives no further toggle. x=40 on a later frame toggles again.
- 90 startOfFrame pulses: rope_en goes 0001 -> 0011 on the 90th. After 270 frames it is 1111, and more frames change nothing.
- level changes 0 -> 2 in the same cycle as startOfFrame: LOAD wins; rope_load pulses once; speeds become {-64, +64, -64, +64}; rope_en=0001; no scan occurs that frame.
- pause=1 for 200 frames with rope0 at x=600: no dir_toggle, rope_en unchanged. On release, the next frame toggles rope0.
- reset asserted in SCAN cycle 1 while rope0 is at a bound: no dir_toggle is emitted, and all outputs show reset values one cycle later.
